// File: rtl/pong_pkg.sv
// Shared Pong definitions: bounce event codes and the referee match states.
// The ball FSM decodes the same bounce codes.
package pong_pkg;

    localparam logic [1:0] BOUNCE_NONE   = 2'b00;
    localparam logic [1:0] BOUNCE_PADDLE = 2'b01;
    localparam logic [1:0] BOUNCE_WALL   = 2'b10;
    localparam logic [1:0] BOUNCE_SERVE  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } ref_state_e;

endpackage

// File: rtl/pong_referee_if.sv
// Bundle between the position registers / ball FSM (master) and the referee (slave).
interface pong_referee_if #(
    parameter int POS_W   = 10,
    parameter int SIZE_W  = 8,
    parameter int SCORE_W = 4
);
    logic               frame_tick;
    logic               start;
    logic [POS_W-1:0]   ball_pos_x;
    logic [POS_W-1:0]   ball_pos_y;
    logic [SIZE_W-1:0]  ball_size_x;
    logic [SIZE_W-1:0]  ball_size_y;
    logic [POS_W-1:0]   paddle_1_pos_x;
    logic [POS_W-1:0]   paddle_1_pos_y;
    logic [SIZE_W-1:0]  paddle_1_size_x;
    logic [SIZE_W-1:0]  paddle_1_size_y;
    logic [POS_W-1:0]   paddle_2_pos_x;
    logic [POS_W-1:0]   paddle_2_pos_y;
    logic [SIZE_W-1:0]  paddle_2_size_x;
    logic [SIZE_W-1:0]  paddle_2_size_y;
    logic [1:0]         bounce;
    logic               bounce_valid;
    logic               serve_dir;
    logic [SCORE_W-1:0] score_player_1;
    logic [SCORE_W-1:0] score_player_2;
    logic               serving;
    logic               game_over;
    logic               winner;

    modport master (
        output frame_tick, start,
        output ball_pos_x, ball_pos_y, ball_size_x, ball_size_y,
        output paddle_1_pos_x, paddle_1_pos_y, paddle_1_size_x, paddle_1_size_y,
        output paddle_2_pos_x, paddle_2_pos_y, paddle_2_size_x, paddle_2_size_y,
        input  bounce, bounce_valid, serve_dir, score_player_1, score_player_2,
        input  serving, game_over, winner
    );

    modport slave (
        input  frame_tick, start,
        input  ball_pos_x, ball_pos_y, ball_size_x, ball_size_y,
        input  paddle_1_pos_x, paddle_1_pos_y, paddle_1_size_x, paddle_1_size_y,
        input  paddle_2_pos_x, paddle_2_pos_y, paddle_2_size_x, paddle_2_size_y,
        output bounce, bounce_valid, serve_dir, score_player_1, score_player_2,
        output serving, game_over, winner
    );

endinterface

// File: rtl/pong_collision_detect.sv
// Combinational geometry tests for one frame: goals, walls and paddle contact.
// Edges are formed one bit wider than the position bus so pos+size never wraps.
module pong_collision_detect #(
    parameter int SCREEN_X = 640,
    parameter int SCREEN_Y = 480,
    parameter int MARGIN   = 5,
    parameter int POS_W    = 10,
    parameter int SIZE_W   = 8
) (
    input  logic [POS_W-1:0]  ball_pos_x,
    input  logic [POS_W-1:0]  ball_pos_y,
    input  logic [SIZE_W-1:0] ball_size_x,
    input  logic [SIZE_W-1:0] ball_size_y,
    input  logic [POS_W-1:0]  paddle_1_pos_x,
    input  logic [POS_W-1:0]  paddle_1_pos_y,
    input  logic [SIZE_W-1:0] paddle_1_size_x,
    input  logic [SIZE_W-1:0] paddle_1_size_y,
    input  logic [POS_W-1:0]  paddle_2_pos_x,
    input  logic [POS_W-1:0]  paddle_2_pos_y,
    input  logic [SIZE_W-1:0] paddle_2_size_x,
    input  logic [SIZE_W-1:0] paddle_2_size_y,
    output logic              goal_right,
    output logic              goal_left,
    output logic              wall_hit,
    output logic              paddle_1_hit,
    output logic              paddle_2_hit
);

    localparam logic [POS_W:0] RIGHT_LIMIT  = (POS_W + 1)'(SCREEN_X - MARGIN);
    localparam logic [POS_W:0] BOTTOM_LIMIT = (POS_W + 1)'(SCREEN_Y - MARGIN);
    localparam logic [POS_W:0] MARGIN_E     = (POS_W + 1)'(MARGIN);

    function automatic logic [POS_W:0] edge_sum(input logic [POS_W-1:0] pos,
                                                input logic [SIZE_W-1:0] size);
        return (POS_W + 1)'(pos) + (POS_W + 1)'(size);
    endfunction

    logic [POS_W:0] ball_left, ball_top, ball_right, ball_bottom;
    logic [POS_W:0] p1_right, p1_top, p1_bottom;
    logic [POS_W:0] p2_left, p2_top, p2_bottom;

    assign ball_left   = (POS_W + 1)'(ball_pos_x);
    assign ball_top    = (POS_W + 1)'(ball_pos_y);
    assign ball_right  = edge_sum(ball_pos_x, ball_size_x);
    assign ball_bottom = edge_sum(ball_pos_y, ball_size_y);
    assign p1_right    = edge_sum(paddle_1_pos_x, paddle_1_size_x);
    assign p1_top      = (POS_W + 1)'(paddle_1_pos_y);
    assign p1_bottom   = edge_sum(paddle_1_pos_y, paddle_1_size_y);
    assign p2_left     = (POS_W + 1)'(paddle_2_pos_x);
    assign p2_top      = (POS_W + 1)'(paddle_2_pos_y);
    assign p2_bottom   = edge_sum(paddle_2_pos_y, paddle_2_size_y);

    // Paddle 2's width does not matter: a ball past its face is already scoring.
    logic unused_p2_width;
    assign unused_p2_width = ^paddle_2_size_x;

    assign goal_right   = ball_right >= RIGHT_LIMIT;
    assign goal_left    = ball_left <= MARGIN_E;
    assign wall_hit     = (ball_bottom >= BOTTOM_LIMIT) || (ball_top <= MARGIN_E);
    assign paddle_1_hit = (ball_left <= p1_right) &&
                          (ball_bottom >= p1_top) && (ball_top <= p1_bottom);
    assign paddle_2_hit = (ball_right >= p2_left) &&
                          (ball_bottom >= p2_top) && (ball_top <= p2_bottom);

endmodule

// File: rtl/pong_referee.sv
// Match referee: per-frame collision priority, bounce strobes, scoring,
// serve delay, win detection and a paddle re-hit cooldown.
module pong_referee #(
    parameter int SCREEN_X        = 640,
    parameter int SCREEN_Y        = 480,
    parameter int MARGIN          = 5,
    parameter int POS_W           = 10,
    parameter int SIZE_W          = 8,
    parameter int SCORE_W         = 4,
    parameter int WIN_SCORE       = 9,
    parameter int SERVE_FRAMES    = 60,
    parameter int COOLDOWN_FRAMES = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    pong_referee_if.slave bus
);
    import pong_pkg::*;

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_SERVE = SERVE;
    localparam logic [1:0] S_PLAY  = PLAY;
    localparam logic [1:0] S_OVER  = OVER;

    localparam int SERVE_W = (SERVE_FRAMES > 0) ? $clog2(SERVE_FRAMES + 1) : 1;
    localparam int COOL_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [SERVE_W-1:0] SERVE_LOAD = SERVE_W'(SERVE_FRAMES);
    localparam logic [COOL_W-1:0]  COOL_LOAD  = COOL_W'(COOLDOWN_FRAMES);
    localparam logic [SCORE_W-1:0] WIN_VALUE  = SCORE_W'(WIN_SCORE);

    logic goal_right, goal_left, wall_hit, paddle_1_hit, paddle_2_hit;

    pong_collision_detect #(
        .SCREEN_X (SCREEN_X),
        .SCREEN_Y (SCREEN_Y),
        .MARGIN   (MARGIN),
        .POS_W    (POS_W),
        .SIZE_W   (SIZE_W)
    ) u_collision (
        .ball_pos_x      (bus.ball_pos_x),
        .ball_pos_y      (bus.ball_pos_y),
        .ball_size_x     (bus.ball_size_x),
        .ball_size_y     (bus.ball_size_y),
        .paddle_1_pos_x  (bus.paddle_1_pos_x),
        .paddle_1_pos_y  (bus.paddle_1_pos_y),
        .paddle_1_size_x (bus.paddle_1_size_x),
        .paddle_1_size_y (bus.paddle_1_size_y),
        .paddle_2_pos_x  (bus.paddle_2_pos_x),
        .paddle_2_pos_y  (bus.paddle_2_pos_y),
        .paddle_2_size_x (bus.paddle_2_size_x),
        .paddle_2_size_y (bus.paddle_2_size_y),
        .goal_right      (goal_right),
        .goal_left       (goal_left),
        .wall_hit        (wall_hit),
        .paddle_1_hit    (paddle_1_hit),
        .paddle_2_hit    (paddle_2_hit)
    );

    logic [1:0]         state_q, state_d;
    logic [SERVE_W-1:0] serve_cnt_q, serve_cnt_d;
    logic [COOL_W-1:0]  cool_cnt_q, cool_cnt_d;
    logic [SCORE_W-1:0] score_1_q, score_1_d;
    logic [SCORE_W-1:0] score_2_q, score_2_d;
    logic [1:0]         bounce_q, bounce_d;
    logic               bounce_valid_q, bounce_valid_d;
    logic               serve_dir_q, serve_dir_d;
    logic               winner_q, winner_d;
    logic [SCORE_W-1:0] scored_new;

    // Goal on the right means player 1 scored; it also has priority over the left goal.
    assign scored_new = (goal_right ? score_1_q : score_2_q) + SCORE_W'(1);

    always_comb begin
        state_d        = state_q;
        serve_cnt_d    = serve_cnt_q;
        cool_cnt_d     = cool_cnt_q;
        score_1_d      = score_1_q;
        score_2_d      = score_2_q;
        serve_dir_d    = serve_dir_q;
        winner_d       = winner_q;
        bounce_d       = BOUNCE_NONE;
        bounce_valid_d = 1'b0;

        if (bus.frame_tick && (cool_cnt_q != '0)) begin
            cool_cnt_d = cool_cnt_q - COOL_W'(1);
        end

        case (state_q)
            S_IDLE, S_OVER: begin
                if (bus.start) begin
                    state_d     = S_SERVE;
                    serve_cnt_d = SERVE_LOAD;
                    cool_cnt_d  = '0;
                    score_1_d   = '0;
                    score_2_d   = '0;
                    serve_dir_d = 1'b0;
                    winner_d    = 1'b0;
                end
            end
            S_SERVE: begin
                // Leaving on the tick that would bring the count to zero holds exactly SERVE_FRAMES ticks.
                if (bus.frame_tick) begin
                    if (serve_cnt_q <= SERVE_W'(1)) begin
                        state_d        = S_PLAY;
                        bounce_d       = BOUNCE_SERVE;
                        bounce_valid_d = 1'b1;
                    end else begin
                        serve_cnt_d = serve_cnt_q - SERVE_W'(1);
                    end
                end
            end
            S_PLAY: begin
                if (bus.frame_tick) begin
                    if (goal_right || goal_left) begin
                        if (goal_right) score_1_d = scored_new;
                        else            score_2_d = scored_new;
                        serve_dir_d = goal_right;
                        if (scored_new == WIN_VALUE) begin
                            state_d  = S_OVER;
                            winner_d = !goal_right;
                        end else begin
                            state_d        = S_SERVE;
                            serve_cnt_d    = SERVE_LOAD;
                            bounce_d       = BOUNCE_SERVE;
                            bounce_valid_d = 1'b1;
                        end
                    end else if (wall_hit) begin
                        bounce_d       = BOUNCE_WALL;
                        bounce_valid_d = 1'b1;
                    end else if ((cool_cnt_q == '0) && (paddle_1_hit || paddle_2_hit)) begin
                        bounce_d       = BOUNCE_PADDLE;
                        bounce_valid_d = 1'b1;
                        cool_cnt_d     = COOL_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            serve_cnt_q    <= '0;
            cool_cnt_q     <= '0;
            score_1_q      <= '0;
            score_2_q      <= '0;
            bounce_q       <= BOUNCE_NONE;
            bounce_valid_q <= 1'b0;
            serve_dir_q    <= 1'b0;
            winner_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            serve_cnt_q    <= serve_cnt_d;
            cool_cnt_q     <= cool_cnt_d;
            score_1_q      <= score_1_d;
            score_2_q      <= score_2_d;
            bounce_q       <= bounce_d;
            bounce_valid_q <= bounce_valid_d;
            serve_dir_q    <= serve_dir_d;
            winner_q       <= winner_d;
        end
    end

    assign bus.bounce         = bounce_q;
    assign bus.bounce_valid   = bounce_valid_q;
    assign bus.serve_dir      = serve_dir_q;
    assign bus.score_player_1 = score_1_q;
    assign bus.score_player_2 = score_2_q;
    assign bus.serving        = (state_q == S_SERVE);
    assign bus.game_over      = (state_q == S_OVER);
    assign bus.winner         = winner_q;

endmodule

// File: tb/tb_pong_referee.sv
// Directed bench for pong_referee: a vector table for in-play rules plus
// hand-written sequences for serve delay, winning, restart and reset.
module tb_pong_referee;
    import pong_pkg::*;

    localparam int POS_W   = 10;
    localparam int SIZE_W  = 8;
    localparam int SCORE_W = 4;

    typedef struct packed {
        logic       v;
        logic [1:0] b;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       dir;
        logic       srv;
        logic       over;
        logic       win;
    } obs_t;

    typedef struct {
        string name;
        int    bx;
        int    by;
        obs_t  exp;
    } vec_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    vec_t vecs[$];

    always #5 clock = ~clock;

    pong_referee_if #(.POS_W(POS_W), .SIZE_W(SIZE_W), .SCORE_W(SCORE_W)) bus ();

    pong_referee #(
        .SCREEN_X(640), .SCREEN_Y(480), .MARGIN(5), .POS_W(POS_W), .SIZE_W(SIZE_W),
        .SCORE_W(SCORE_W), .WIN_SCORE(9), .SERVE_FRAMES(60), .COOLDOWN_FRAMES(4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic obs_t mk(input logic v, input logic [1:0] b, input int s1, input int s2,
                                input logic dir, input logic srv, input logic over, input logic win);
        obs_t o;
        o.v = v; o.b = b; o.s1 = 4'(s1); o.s2 = 4'(s2);
        o.dir = dir; o.srv = srv; o.over = over; o.win = win;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.v = bus.bounce_valid; o.b = bus.bounce;
        o.s1 = bus.score_player_1; o.s2 = bus.score_player_2;
        o.dir = bus.serve_dir; o.srv = bus.serving;
        o.over = bus.game_over; o.win = bus.winner;
        return o;
    endfunction

    task automatic expect_obs(input string name, input obs_t e);
        obs_t a;
        a = sample();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got v=%b b=%b s1=%0d s2=%0d dir=%b srv=%b over=%b win=%b, expected v=%b b=%b s1=%0d s2=%0d dir=%b srv=%b over=%b win=%b",
                     name, a.v, a.b, a.s1, a.s2, a.dir, a.srv, a.over, a.win,
                     e.v, e.b, e.s1, e.s2, e.dir, e.srv, e.over, e.win);
        end
    endtask

    task automatic set_ball(input int x, input int y);
        bus.ball_pos_x = POS_W'(x);
        bus.ball_pos_y = POS_W'(y);
    endtask

    // One frame tick; outputs checked half a cycle after the sampling edge, then one cycle later.
    task automatic tick_and_check(input string name, input logic st, input obs_t e);
        obs_t e2;
        bus.frame_tick = 1'b1;
        bus.start      = st;
        @(negedge clock);
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        expect_obs(name, e);
        @(negedge clock);
        e2 = e;
        e2.v = 1'b0;
        e2.b = BOUNCE_NONE;
        expect_obs({name, "_clear"}, e2);
    endtask

    task automatic drain_serve(input int s1, input int s2, input logic dir, input logic poke_start);
        for (int i = 1; i < 60; i++)
            tick_and_check("serve_hold", poke_start && (i == 30), mk(0, BOUNCE_NONE, s1, s2, dir, 1, 0, 0));
        tick_and_check("serve_exit", 1'b0, mk(1, BOUNCE_SERVE, s1, s2, dir, 0, 0, 0));
        $display("serve done: scores %0d/%0d dir=%0d", s1, s2, dir);
    endtask

    task automatic add_vec(input string n, input int bx, input int by, input obs_t e);
        vec_t t;
        t.name = n; t.bx = bx; t.by = by; t.exp = e;
        vecs.push_back(t);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s1;
        int s2;

        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        set_ball(300, 200);
        bus.ball_size_x     = 8'd8;  bus.ball_size_y     = 8'd8;
        bus.paddle_1_pos_x  = 10'd10;  bus.paddle_1_pos_y = 10'd180;
        bus.paddle_1_size_x = 8'd10; bus.paddle_1_size_y = 8'd60;
        bus.paddle_2_pos_x  = 10'd620; bus.paddle_2_pos_y = 10'd180;
        bus.paddle_2_size_x = 8'd10; bus.paddle_2_size_y = 8'd60;

        add_vec("neutral",       300, 200, mk(0, BOUNCE_NONE,   0, 0, 0, 0, 0, 0));
        add_vec("wall_top",      300,   5, mk(1, BOUNCE_WALL,   0, 0, 0, 0, 0, 0));
        add_vec("wall_bottom",   300, 467, mk(1, BOUNCE_WALL,   0, 0, 0, 0, 0, 0));
        add_vec("near_bottom",   300, 466, mk(0, BOUNCE_NONE,   0, 0, 0, 0, 0, 0));
        add_vec("paddle1",        20, 200, mk(1, BOUNCE_PADDLE, 0, 0, 0, 0, 0, 0));
        add_vec("p1_cool_a",      20, 200, mk(0, BOUNCE_NONE,   0, 0, 0, 0, 0, 0));
        add_vec("p1_cool_b",      20, 200, mk(0, BOUNCE_NONE,   0, 0, 0, 0, 0, 0));
        add_vec("cool_drain_a",  300, 200, mk(0, BOUNCE_NONE,   0, 0, 0, 0, 0, 0));
        add_vec("cool_drain_b",  300, 200, mk(0, BOUNCE_NONE,   0, 0, 0, 0, 0, 0));
        add_vec("paddle1_again",  20, 200, mk(1, BOUNCE_PADDLE, 0, 0, 0, 0, 0, 0));
        add_vec("wall_in_cool",  300,   5, mk(1, BOUNCE_WALL,   0, 0, 0, 0, 0, 0));
        add_vec("cool_drain_c",  300, 200, mk(0, BOUNCE_NONE,   0, 0, 0, 0, 0, 0));
        add_vec("cool_drain_d",  300, 200, mk(0, BOUNCE_NONE,   0, 0, 0, 0, 0, 0));
        add_vec("cool_drain_e",  300, 200, mk(0, BOUNCE_NONE,   0, 0, 0, 0, 0, 0));
        add_vec("paddle2",       612, 200, mk(1, BOUNCE_PADDLE, 0, 0, 0, 0, 0, 0));
        add_vec("goal_left",       5, 200, mk(1, BOUNCE_SERVE,  0, 1, 0, 1, 0, 0));
        add_vec("left_edge_p1",    6, 200, mk(1, BOUNCE_PADDLE, 0, 1, 0, 0, 0, 0));
        add_vec("goal_over_wall",627, 470, mk(1, BOUNCE_SERVE,  1, 1, 1, 1, 0, 0));
        add_vec("right_edge_p2", 626, 200, mk(1, BOUNCE_PADDLE, 1, 1, 1, 0, 0, 0));

        // Reset state, and no activity in IDLE without start.
        repeat (3) @(negedge clock);
        expect_obs("reset_state", mk(0, BOUNCE_NONE, 0, 0, 0, 0, 0, 0));
        reset_n = 1'b1;
        @(negedge clock);
        set_ball(5, 200);
        tick_and_check("idle_tick", 1'b0, mk(0, BOUNCE_NONE, 0, 0, 0, 0, 0, 0));

        // Start without a tick, then the 60-frame serve with a stray start mid-way.
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        expect_obs("start_to_serve", mk(0, BOUNCE_NONE, 0, 0, 0, 1, 0, 0));
        drain_serve(0, 0, 1'b0, 1'b1);

        foreach (vecs[i]) begin
            set_ball(vecs[i].bx, vecs[i].by);
            tick_and_check(vecs[i].name, 1'b0, vecs[i].exp);
            $display("vec %0d %s applied", i, vecs[i].name);
            if (vecs[i].exp.srv)
                drain_serve(vecs[i].exp.s1, vecs[i].exp.s2, vecs[i].exp.dir, 1'b0);
        end

        // Player 1 runs the score from 1 to the winning 9.
        set_ball(627, 200);
        for (int k = 2; k <= 8; k++) begin
            tick_and_check("goal_p1", 1'b0, mk(1, BOUNCE_SERVE, k, 1, 1, 1, 0, 0));
            drain_serve(k, 1, 1'b1, 1'b0);
        end
        tick_and_check("win_p1", 1'b0, mk(0, BOUNCE_NONE, 9, 1, 1, 0, 1, 0));
        $display("game over: winner player 1");
        set_ball(5, 200);
        tick_and_check("over_hold_a", 1'b0, mk(0, BOUNCE_NONE, 9, 1, 1, 0, 1, 0));
        set_ball(300, 5);
        tick_and_check("over_hold_b", 1'b0, mk(0, BOUNCE_NONE, 9, 1, 1, 0, 1, 0));

        // Restart with start coincident with a goal-position tick: start wins.
        set_ball(627, 200);
        tick_and_check("restart_start_wins", 1'b1, mk(0, BOUNCE_NONE, 0, 0, 0, 1, 0, 0));
        drain_serve(0, 0, 1'b0, 1'b0);

        // Build scores 3/2, then reset while a scoring strobe is on the outputs.
        s1 = 0;
        s2 = 0;
        for (int k = 0; k < 5; k++) begin
            if (k < 3) begin
                set_ball(627, 200);
                s1++;
            end else begin
                set_ball(5, 200);
                s2++;
            end
            tick_and_check("build_score", 1'b0, mk(1, BOUNCE_SERVE, s1, s2, (k < 3), 1, 0, 0));
            drain_serve(s1, s2, (k < 3), 1'b0);
        end
        set_ball(627, 200);
        bus.frame_tick = 1'b1;
        @(posedge clock);
        #1;
        bus.frame_tick = 1'b0;
        expect_obs("pre_reset_strobe", mk(1, BOUNCE_SERVE, 4, 2, 1, 1, 0, 0));
        reset_n = 1'b0;
        #1;
        expect_obs("async_reset", mk(0, BOUNCE_NONE, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        expect_obs("after_release", mk(0, BOUNCE_NONE, 0, 0, 0, 0, 0, 0));
        tick_and_check("idle_after_reset", 1'b0, mk(0, BOUNCE_NONE, 0, 0, 0, 0, 0, 0));
        $display("reset sequence done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
